// File: rtl/ring_pkg.sv
// Shared types and helpers for the one-hot ring count decoder.
package ring_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Widest ring the rotate helpers support; the callers zero-extend into this.
    localparam int RING_MAX_W = 64;

    function automatic logic [RING_MAX_W-1:0] ring_mask(input int unsigned w);
        return (w >= RING_MAX_W) ? '1 : ((RING_MAX_W'(1) << w) - RING_MAX_W'(1));
    endfunction

    function automatic logic [RING_MAX_W-1:0] rotl(input logic [RING_MAX_W-1:0] v,
                                                    input int unsigned        w);
        return ((v << 1) | (v >> (w - 1))) & ring_mask(w);
    endfunction

    function automatic logic [RING_MAX_W-1:0] rotr(input logic [RING_MAX_W-1:0] v,
                                                    input int unsigned        w);
        return ((v >> 1) | (v << (w - 1))) & ring_mask(w);
    endfunction

endpackage

// File: rtl/onehot_enc.sv
// Combinational one-hot check and binary encoder for a WIDTH-bit vector.
module onehot_enc #(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             is_onehot
);

    logic seen;
    logic multi;

    // NOTE: every variable assigned in always_comb gets a default first; a path
    // that skips an assignment would otherwise infer a latch.
    always_comb begin
        idx   = '0;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                if (seen) multi = 1'b1;
                seen = 1'b1;
                idx  = IDX_W'(i);
            end
        end
        is_onehot = seen & ~multi;
    end

endmodule

// File: rtl/ring_count_decoder.sv
// Monitor/decoder for a one-hot ring count stream: lock, error flags, rotation count.
// Define RING_BIDIR_EN to accept right-rotating rings (direction latched into dir).
module ring_count_decoder
    import ring_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 2,
    parameter int ROT_W    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         ring_in,
    input  logic                     ring_valid,
    output logic [$clog2(WIDTH)-1:0] index,
    output logic                     index_valid,
    output logic                     locked,
    output logic                     seq_err,
    output logic                     onehot_err,
    output logic [ROT_W-1:0]         rotations,
    output logic                     rot_wrap,
    output logic                     dir
);

    localparam int IDX_W  = $clog2(WIDTH);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);

    state_t            state, state_n;
    logic [WIDTH-1:0]  prev, prev_n;
    logic [GOOD_W-1:0] good, good_n, good_inc;
    logic [IDX_W-1:0]  index_n;
    logic              index_valid_n, seq_err_n, onehot_err_n, rot_wrap_n;
    logic [ROT_W-1:0]  rotations_n;

    logic [IDX_W-1:0]  enc_idx;
    logic              enc_onehot;
    logic [WIDTH-1:0]  exp_left;
    logic              step_left;
    logic              succ_ok;
    logic              succ_dir;
    logic              wrap_edge;

    onehot_enc #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_enc (
        .vec       (ring_in),
        .idx       (enc_idx),
        .is_onehot (enc_onehot)
    );

    assign exp_left  = WIDTH'(rotl(RING_MAX_W'(prev), WIDTH));
    assign step_left = (ring_in == exp_left);
    assign good_inc  = good + GOOD_W'(1);

`ifdef RING_BIDIR_EN
    logic             dir_q, dir_n;
    logic [WIDTH-1:0] exp_right;
    logic             step_right;

    assign exp_right  = WIDTH'(rotr(RING_MAX_W'(prev), WIDTH));
    assign step_right = (ring_in == exp_right);
    assign dir        = dir_q;

    // Direction is free only on the first transition after (re)entering TRACK.
    always_comb begin
        succ_ok  = 1'b0;
        succ_dir = dir_q;
        if (state == TRACK && good == '0) begin
            if (step_left) begin
                succ_ok  = 1'b1;
                succ_dir = DIR_LEFT;
            end else if (step_right) begin
                succ_ok  = 1'b1;
                succ_dir = DIR_RIGHT;
            end
        end else begin
            succ_ok = (dir_q == DIR_RIGHT) ? step_right : step_left;
        end
        wrap_edge = (dir_q == DIR_RIGHT) ? (prev[0] & ring_in[WIDTH-1])
                                         : (prev[WIDTH-1] & ring_in[0]);
    end
`else
    assign dir       = DIR_LEFT;
    assign succ_ok   = step_left;
    assign succ_dir  = DIR_LEFT;
    assign wrap_edge = prev[WIDTH-1] & ring_in[0];
`endif

    always_comb begin
        state_n       = state;
        prev_n        = prev;
        good_n        = good;
        index_n       = index;
        index_valid_n = 1'b0;
        seq_err_n     = 1'b0;
        onehot_err_n  = 1'b0;
        rotations_n   = rotations;
        rot_wrap_n    = 1'b0;
`ifdef RING_BIDIR_EN
        dir_n         = dir_q;
`endif
        if (ring_valid) begin
            if (!enc_onehot) begin
                onehot_err_n = 1'b1;
                state_n      = HUNT;
                good_n       = '0;
                prev_n       = '0;
            end else begin
                index_n       = enc_idx;
                index_valid_n = 1'b1;
                prev_n        = ring_in;
                case (state)
                    HUNT: begin
                        state_n = TRACK;
                        good_n  = '0;
                    end
                    TRACK: begin
                        if (succ_ok) begin
`ifdef RING_BIDIR_EN
                            dir_n  = succ_dir;
`endif
                            good_n = good_inc;
                            if (good_inc == GOOD_W'(LOCK_CNT)) state_n = LOCKED;
                        end else begin
                            seq_err_n = 1'b1;
                            good_n    = '0;
                        end
                    end
                    LOCKED: begin
                        if (succ_ok) begin
                            if (wrap_edge) begin
                                rotations_n = rotations + ROT_W'(1);
                                rot_wrap_n  = &rotations;
                            end
                        end else begin
                            seq_err_n = 1'b1;
                            state_n   = TRACK;
                            good_n    = '0;
                        end
                    end
                    default: begin
                        state_n = HUNT;
                        good_n  = '0;
                    end
                endcase
            end
        end
    end

`ifndef RING_BIDIR_EN
    logic unused_succ_dir;
    assign unused_succ_dir = succ_dir;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= HUNT;
            prev        <= '0;
            good        <= '0;
            index       <= '0;
            index_valid <= 1'b0;
            locked      <= 1'b0;
            seq_err     <= 1'b0;
            onehot_err  <= 1'b0;
            rotations   <= '0;
            rot_wrap    <= 1'b0;
`ifdef RING_BIDIR_EN
            dir_q       <= DIR_LEFT;
`endif
        end else begin
            state       <= state_n;
            prev        <= prev_n;
            good        <= good_n;
            index       <= index_n;
            index_valid <= index_valid_n;
            locked      <= (state_n == LOCKED);
            seq_err     <= seq_err_n;
            onehot_err  <= onehot_err_n;
            rotations   <= rotations_n;
            rot_wrap    <= rot_wrap_n;
`ifdef RING_BIDIR_EN
            dir_q       <= dir_n;
`endif
        end
    end

endmodule

// File: tb/tb_ring_count_decoder.sv
// Self-checking bench: directed scenarios plus random stream against a positional model.
module tb_ring_count_decoder;

    localparam int WIDTH    = 4;
    localparam int LOCK_CNT = 2;
    localparam int ROT_W    = 4;
    localparam int IDX_W    = $clog2(WIDTH);

    logic                clk = 1'b0;
    logic                reset;
    logic [WIDTH-1:0]    ring_in;
    logic                ring_valid;
    logic [IDX_W-1:0]    index;
    logic                index_valid;
    logic                locked;
    logic                seq_err;
    logic                onehot_err;
    logic [ROT_W-1:0]    rotations;
    logic                rot_wrap;
    logic                dir;

    always #5 clk = ~clk;

    ring_count_decoder #(
        .WIDTH    (WIDTH),
        .LOCK_CNT (LOCK_CNT),
        .ROT_W    (ROT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ring_in     (ring_in),
        .ring_valid  (ring_valid),
        .index       (index),
        .index_valid (index_valid),
        .locked      (locked),
        .seq_err     (seq_err),
        .onehot_err  (onehot_err),
        .rotations   (rotations),
        .rot_wrap    (rot_wrap),
        .dir         (dir)
    );

    int checks = 0;
    int errors = 0;

    // Model: position of last accepted bit (-1 = none), run length, lock flag.
    int m_prev = -1;
    int m_good = 0;
    int m_locked = 0;
    int m_dir = 0;
    int m_rot = 0;
    int e_index = 0, e_iv = 0, e_seq = 0, e_oh = 0, e_wrap = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input logic [WIDTH-1:0] d);
        int ones, pos, stepd;
        bit left_ok, right_ok, ok;
        e_iv = 0; e_seq = 0; e_oh = 0; e_wrap = 0;
        if (!r) begin
            m_prev = -1; m_good = 0; m_locked = 0; m_dir = 0; m_rot = 0; e_index = 0;
            return;
        end
        if (!v) return;
        ones = 0; pos = 0;
        for (int i = 0; i < WIDTH; i++) if (d[i]) begin ones++; pos = i; end
        if (ones != 1) begin
            e_oh = 1; m_prev = -1; m_good = 0; m_locked = 0;
            return;
        end
        e_index = pos; e_iv = 1;
        if (m_prev < 0) begin
            m_prev = pos; m_good = 0;
            return;
        end
        stepd    = (pos - m_prev + WIDTH) % WIDTH;
        left_ok  = (stepd == 1);
        right_ok = (stepd == WIDTH - 1);
`ifdef RING_BIDIR_EN
        if (!m_locked && m_good == 0) begin
            ok = 1'b1;
            if (left_ok) m_dir = 0;
            else if (right_ok) m_dir = 1;
            else ok = 1'b0;
        end else begin
            ok = (m_dir == 1) ? right_ok : left_ok;
        end
`else
        ok = left_ok;
`endif
        if (ok) begin
            if (m_locked) begin
                if ((m_dir == 0 && m_prev == WIDTH - 1 && pos == 0) ||
                    (m_dir == 1 && m_prev == 0 && pos == WIDTH - 1)) begin
                    m_rot  = (m_rot + 1) % (1 << ROT_W);
                    e_wrap = (m_rot == 0);
                end
            end else begin
                m_good++;
                if (m_good >= LOCK_CNT) m_locked = 1;
            end
        end else begin
            e_seq = 1; m_good = 0; m_locked = 0;
        end
        m_prev = pos;
    endtask

    task automatic compare_all();
        check("index",       32'(index),       32'(e_index));
        check("index_valid", 32'(index_valid), 32'(e_iv));
        check("locked",      32'(locked),      32'(m_locked));
        check("seq_err",     32'(seq_err),     32'(e_seq));
        check("onehot_err",  32'(onehot_err),  32'(e_oh));
        check("rotations",   32'(rotations),   32'(m_rot));
        check("rot_wrap",    32'(rot_wrap),    32'(e_wrap));
        check("dir",         32'(dir),         32'(m_dir));
    endtask

    task automatic cycle(input bit r, input bit v, input logic [WIDTH-1:0] d);
        reset = r; ring_valid = v; ring_in = d;
        model_step(r, v, d);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        int pos_drv;
        bit rdir, r, v;
        int choice;
        logic [WIDTH-1:0] d;

        reset = 1'b0; ring_valid = 1'b0; ring_in = '0;

        // Reset and lock-up
        cycle(0, 0, 4'b0000);
        cycle(0, 1, 4'b0001);
        check("lit_rst_locked", 32'(locked), 0);
        check("lit_rst_rot", 32'(rotations), 0);
        cycle(1, 1, 4'b0001); check("lit_idx0", 32'(index), 0);
        cycle(1, 1, 4'b0010); check("lit_idx1", 32'(index), 1);
        check("lit_unlocked", 32'(locked), 0);
        cycle(1, 1, 4'b0100); check("lit_idx2", 32'(index), 2);
        check("lit_lock", 32'(locked), 1);
        cycle(1, 1, 4'b1000); check("lit_idx3", 32'(index), 3);
        cycle(1, 1, 4'b0001); check("lit_rot1", 32'(rotations), 1);
        check("lit_rot1_wrap", 32'(rot_wrap), 0);

        // One-hot error and re-lock
        cycle(1, 1, 4'b0010);
        cycle(1, 1, 4'b0100);
        cycle(1, 1, 4'b1000);
        cycle(1, 1, 4'b0110);
        check("lit_oh_err", 32'(onehot_err), 1);
        check("lit_oh_idx", 32'(index), 3);
        check("lit_oh_iv", 32'(index_valid), 0);
        check("lit_oh_locked", 32'(locked), 0);
        cycle(1, 1, 4'b0001);
        cycle(1, 1, 4'b0010);
        cycle(1, 1, 4'b0100); check("lit_relock", 32'(locked), 1);

        // Sequence error and re-lock
        cycle(1, 1, 4'b1000);
        cycle(1, 1, 4'b0001);
        cycle(1, 1, 4'b0010);
        cycle(1, 1, 4'b1000);
        check("lit_seq_err", 32'(seq_err), 1);
        check("lit_seq_locked", 32'(locked), 0);
        check("lit_seq_idx", 32'(index), 3);
        check("lit_seq_iv", 32'(index_valid), 1);
        cycle(1, 1, 4'b0001);
        cycle(1, 1, 4'b0010); check("lit_seq_relock", 32'(locked), 1);

        // Valid gaps then mid-run reset
        for (int i = 0; i < 3; i++) cycle(1, 0, 4'b1111);
        check("lit_gap_locked", 32'(locked), 1);
        check("lit_gap_oh", 32'(onehot_err), 0);
        cycle(0, 1, 4'b0100);
        check("lit_rst2_locked", 32'(locked), 0);
        check("lit_rst2_iv", 32'(index_valid), 0);
        check("lit_rst2_rot", 32'(rotations), 0);

        // Rotation counter wrap
        cycle(1, 1, 4'b0001);
        cycle(1, 1, 4'b0010);
        cycle(1, 1, 4'b0100);
        cycle(1, 1, 4'b1000);
        for (int k = 0; k < (1 << ROT_W); k++) begin
            cycle(1, 1, 4'b0001);
            if (k == (1 << ROT_W) - 1) begin
                check("lit_wrap_rot", 32'(rotations), 0);
                check("lit_wrap_pulse", 32'(rot_wrap), 1);
            end
            cycle(1, 1, 4'b0010);
            if (k == (1 << ROT_W) - 1) check("lit_wrap_once", 32'(rot_wrap), 0);
            cycle(1, 1, 4'b0100);
            cycle(1, 1, 4'b1000);
        end

`ifdef RING_BIDIR_EN
        cycle(0, 0, 4'b0000);
        cycle(1, 1, 4'b1000);
        cycle(1, 1, 4'b0100);
        cycle(1, 1, 4'b0010);
        cycle(1, 1, 4'b0001);
        check("lit_bidir_dir", 32'(dir), 1);
        check("lit_bidir_lock", 32'(locked), 1);
        cycle(1, 1, 4'b1000);
        check("lit_bidir_rot", 32'(rotations), 1);
        check("lit_bidir_seq", 32'(seq_err), 0);
`endif

        // Random stream: mostly well-formed sequence with injected faults
        pos_drv = 0;
        rdir = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            r = ($urandom_range(0, 199) != 0);
            v = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) == 0) rdir = ~rdir;
            choice = $urandom_range(0, 29);
            if (choice == 0) begin
                d = WIDTH'($urandom);
            end else if (choice == 1) begin
                pos_drv = $urandom_range(0, WIDTH - 1);
                d = WIDTH'(1) << pos_drv;
            end else begin
                if (v) pos_drv = rdir ? (pos_drv + WIDTH - 1) % WIDTH : (pos_drv + 1) % WIDTH;
                d = WIDTH'(1) << pos_drv;
            end
            cycle(r, v, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
